pm_sort_seq: RTL

Sequential, parametrised path-metric sorter for the SCL list decoder. It accepts 2L candidate path metrics, tags each with its candidate index, and sorts them with one odd-even transposition pass per clock. A pass counter and swap detection let it finish early. It returns the L smallest metrics with their indices through valid/ready handshakes. It replaces the fixed L=4 combinational sorter where larger lists or timing closure require iteration over a single compare-and-swap row.

---
 rtl/pm_sort_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pm_sort_seq.sv
// Iterative path-metric sorter: one odd-even transposition pass per clock over
// 2L tagged candidates, early exit after two swap-free passes, L smallest out.
//
// state | meaning
// IDLE  | in_ready high, waiting for a candidate vector
// SORT  | one compare-and-swap row per cycle on the working array
// DONE  | out_valid high, result held until out_ready
module pm_sort_seq #(
   parameter int PM_WIDTH    = 8,
   parameter int L           = 4,
   parameter int INDEX_WIDTH = 3,
   parameter int PASS_WIDTH  = 5
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [PM_WIDTH*2*L-1:0]               pm_in,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [(PM_WIDTH+INDEX_WIDTH)*L-1:0]   pm_out,
   output logic [PASS_WIDTH-1:0]                 pass_cnt
);

   localparam int N  = 2 * L;
   localparam int EW = PM_WIDTH + INDEX_WIDTH;

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                 state_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [EW*L-1:0]        pm_out_q;
   logic [PASS_WIDTH-1:0]  pass_cnt_q;

   logic [PM_WIDTH-1:0]    pm_q  [N];
   logic [PM_WIDTH-1:0]    pm_d  [N];
   logic [INDEX_WIDTH-1:0] idx_q [N];
   logic [INDEX_WIDTH-1:0] idx_d [N];
   logic [PASS_WIDTH-1:0]  pass_q;
   logic [PASS_WIDTH-1:0]  pass_d;
   logic                   swap_prev_q;
   logic                   swap_now;
   logic                   sort_end;
   logic [EW*L-1:0]        pm_out_d;

   // Pass k = pass_q+1; odd k pairs start at position 0, even k at position 1.
   always_comb begin
      pass_d   = pass_q + 1'b1;
      swap_now = 1'b0;
      pm_out_d = '0;
      for (int i = 0; i < N; i++) begin
         pm_d[i]  = pm_q[i];
         idx_d[i] = idx_q[i];
      end
      for (int i = 0; i < N - 1; i++) begin
         if ((i[0] == pass_q[0]) && (pm_q[i] > pm_q[i+1])) begin
            pm_d[i]    = pm_q[i+1];
            pm_d[i+1]  = pm_q[i];
            idx_d[i]   = idx_q[i+1];
            idx_d[i+1] = idx_q[i];
            swap_now   = 1'b1;
         end
      end
      sort_end = ((pass_d >= PASS_WIDTH'(2)) && !swap_now && !swap_prev_q) ||
                 (pass_d == PASS_WIDTH'(N));
      for (int j = 0; j < L; j++)
         pm_out_d[(L-1-j)*EW +: EW] = {idx_d[j], pm_d[j]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         pm_out_q    <= '0;
         pass_cnt_q  <= '0;
         pass_q      <= '0;
         swap_prev_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            pm_q[i]  <= '0;
            idx_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < N; i++) begin
                     pm_q[i]  <= pm_in[(N-1-i)*PM_WIDTH +: PM_WIDTH];
                     idx_q[i] <= INDEX_WIDTH'(i);
                  end
                  pass_q      <= '0;
                  swap_prev_q <= 1'b0;
                  in_ready_q  <= 1'b0;
                  state_q     <= SORT;
               end
            end
            SORT: begin
               pm_q        <= pm_d;
               idx_q       <= idx_d;
               pass_q      <= pass_d;
               swap_prev_q <= swap_now;
               if (sort_end) begin
                  pm_out_q    <= pm_out_d;
                  pass_cnt_q  <= pass_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign pm_out    = pm_out_q;
   assign pass_cnt  = pass_cnt_q;

endmodule
